// File: rtl/eq_pipe_pkg.sv
// eq_pipe_pkg: shared result type and buffer defaults for the equation pipeline and its output buffer
package eq_pipe_pkg;
  localparam int RESULT_W = 16;
  typedef logic [RESULT_W-1:0] result_t;
  localparam int BUF_DEPTH_DEFAULT = 4;
endpackage

// File: rtl/eq_fifo_mem.sv
// eq_fifo_mem: DEPTH x DATA_W register array, one write port, one async read port, no storage reset
module eq_fifo_mem import eq_pipe_pkg::*; #(
  parameter int DATA_W = RESULT_W,
  parameter int DEPTH = BUF_DEPTH_DEFAULT,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // write the accepted result into its slot
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/eq_result_buffer.sv
// eq_result_buffer: FIFO output stage with registered stall back to the pipeline; BUF_STATS_EN adds stall_cycles/accept_cnt
module eq_result_buffer import eq_pipe_pkg::*; #(
  parameter int DATA_W = RESULT_W,
  parameter int DEPTH = BUF_DEPTH_DEFAULT,
  parameter int STALL_THRESH = DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              stall,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     count
`ifdef BUF_STATS_EN
  ,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       accept_cnt
`endif
);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_next;
  logic [DATA_W-1:0] rdata;
  logic push, pop;
  assign push = in_valid & ~stall;
  assign out_valid = count != '0;
  assign pop = out_valid & out_ready;
  assign out_data = out_valid ? rdata : '0;
  assign count_next = count + CW'(push) - CW'(pop);
  eq_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk(clk), .we(push), .waddr(wr_ptr), .wdata(in_data), .raddr(rd_ptr), .rdata(rdata)
  );
  // advance pointers and occupancy; stall follows the post-update occupancy
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      stall <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count_next;
      stall <= count_next >= CW'(STALL_THRESH);
    end
`ifdef BUF_STATS_EN
  // saturating counts of stalled cycles and accepted results
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stall_cycles <= '0;
      accept_cnt <= '0;
    end else begin
      if (stall && ~&stall_cycles) stall_cycles <= stall_cycles + 16'd1;
      if (push && ~&accept_cnt) accept_cnt <= accept_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_eq_result_buffer.sv
// tb_eq_result_buffer: randomized scoreboard bench for eq_result_buffer (stats checks when BUF_STATS_EN is defined)
module tb_eq_result_buffer;
  import eq_pipe_pkg::*;
  localparam int DEPTH = 4;
  localparam int THRESH = 4;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 0;
  logic [15:0] in_data = 0;
  logic stall, out_valid;
  logic [15:0] out_data;
  logic [2:0] count;
`ifdef BUF_STATS_EN
  logic [15:0] stall_cycles, accept_cnt;
`endif
  int checks = 0, errors = 0;
  bit mon_en = 0;
  logic [15:0] exp_q[$];
  bit mstall = 0;
  int m_sc = 0, m_acc = 0;

  eq_result_buffer #(.DATA_W(16), .DEPTH(DEPTH), .STALL_THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .stall(stall),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count)
`ifdef BUF_STATS_EN
    , .stall_cycles(stall_cycles), .accept_cnt(accept_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: FIFO contents as a queue, stall derived from occupancy
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      mstall = 0;
      m_sc = 0;
      m_acc = 0;
    end else begin
      bit push, pop;
      push = in_valid && !mstall;
      pop = exp_q.size() != 0 && out_ready;
      if (mstall && m_sc < 65535) m_sc++;
      if (push && m_acc < 65535) m_acc++;
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back(in_data);
      mstall = exp_q.size() >= THRESH;
    end
  end

  // monitor: compare presented outputs against the scoreboard head
  always @(negedge clk) if (mon_en) begin
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("stall", 32'(stall), 32'(mstall));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("out_data", 32'(out_data), exp_q.size() != 0 ? 32'(exp_q[0]) : 32'd0);
`ifdef BUF_STATS_EN
    chk("stall_cycles", 32'(stall_cycles), 32'(m_sc));
    chk("accept_cnt", 32'(accept_cnt), 32'(m_acc));
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [15:0] w);
    bit s;
    int n = 0;
    in_valid = 1;
    in_data = w;
    do begin
      s = stall;
      cyc();
      n++;
    end while (s && n < 64);
    if (s) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word %0h still stalled after %0d cycles", w, n);
    end
    in_valid = 0;
  endtask

  initial begin
    bit s;
    cyc();
    mon_en = 1;
    repeat (2) begin
      in_valid = 1'($urandom);
      in_data = 16'($urandom);
      out_ready = 1'($urandom);
      cyc();
    end
    chk("reset_count", 32'(count), 0);
    chk("reset_out_data", 32'(out_data), 0);
    in_valid = 0;
    rst = 1;
    cyc();
    out_ready = 1;
    send(16'h1234);
    chk("pass_head", 32'(out_data), 32'h1234);
    send(16'h0001);
    send(16'h0000);
    repeat (3) cyc();
    chk("pass_drained", 32'(count), 0);
    out_ready = 0;
    for (int i = 0; i < 4; i++) send(16'hA000 + 16'(i));
    in_valid = 1;
    in_data = 16'hA004;
    repeat (3) begin
      chk("fill_stall", 32'(stall), 1);
      chk("fill_count", 32'(count), 4);
      cyc();
    end
    out_ready = 1;
    send(16'hA004);
    repeat (6) cyc();
    chk("fill_drained", 32'(count), 0);
    out_ready = 0;
    send(16'hB000);
    send(16'hB001);
    chk("simul_pre", 32'(count), 2);
    out_ready = 1;
    for (int i = 0; i < 3 * DEPTH + 2; i++) begin
      send(16'hB002 + 16'(i));
      chk("simul_count", 32'(count), 2);
    end
    repeat (4) cyc();
    s = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && s)) begin
        in_valid = 1'($urandom);
        in_data = 16'($urandom);
      end
      out_ready = $urandom_range(0, 99) < (i < 200 ? 30 : 80);
      s = stall;
      cyc();
    end
    in_valid = 0;
    out_ready = 1;
    repeat (8) cyc();
    out_ready = 0;
    send(16'hC000);
    send(16'hC001);
    send(16'hC002);
    chk("mid_pre_count", 32'(count), 3);
    @(posedge clk);
    #3 rst = 0;
    #1;
    chk("mid_count", 32'(count), 0);
    chk("mid_out_valid", 32'(out_valid), 0);
    chk("mid_out_data", 32'(out_data), 0);
    chk("mid_stall", 32'(stall), 0);
    cyc();
    cyc();
    rst = 1;
    out_ready = 1;
    send(16'hD00D);
    chk("post_reset_head", 32'(out_data), 32'hD00D);
    chk("post_reset_count", 32'(count), 1);
    repeat (3) cyc();
`ifdef BUF_STATS_EN
    in_valid = 1;
    repeat (70000) begin
      in_data = 16'($urandom);
      cyc();
    end
    in_valid = 0;
    repeat (4) cyc();
    chk("accept_sat", 32'(accept_cnt), 32'hFFFF);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
